fp_dot_acc: RTL and testbench

Streaming Q16.16 dot-product accumulator; the sequential stage directly downstream of the fp_mul/fp_add primitives.
- Accepts one (a,b) operand pair per beat and multiplies it with an fp_mul instance.
- Accumulates products with an fp_add instance and emits one saturating sum per vector, terminated by s_last.
- Sits between the operand fetch logic and the activation/writeback stage of the ML datapath.

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_add.sv | 32 +++
 rtl/fp_mul.sv | 42 ++++
 rtl/fp_dot_acc.sv | 138 +++++++++++++
 tb/tb_fp_dot_acc.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared Q-format constants, types and dot-accumulator states
// Holds the default fixed-point geometry (Q16.16), the saturation limits,
// the value 1.0, a signed Q typedef and the dot-accumulator FSM encoding.
package fp_pkg;

  localparam int FP_WIDTH    = 32;
  localparam int FP_FRACTION = 16;

  localparam logic [FP_WIDTH-1:0] FP_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
  localparam logic [FP_WIDTH-1:0] FP_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};
  localparam logic [FP_WIDTH-1:0] FP_ONE = FP_WIDTH'(1) << FP_FRACTION;

  typedef logic signed [FP_WIDTH-1:0] q_t;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } dot_state_t;

endpackage

// File: rtl/fp_add.sv
// rtl/fp_add.sv - signed fixed-point add with saturation
// Ports: a, b  signed Q operands
//        y     sum, clamped to the Q range
//        sat   sum overflowed and was clamped
module fp_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // Overflow shows up as disagreement between the guard and sign bits.
    sat = sum[WIDTH] != sum[WIDTH-1];
    if (!sat) begin
      y = sum[WIDTH-1:0];
    end else if (sum[WIDTH]) begin
      y = Q_MIN;
    end else begin
      y = Q_MAX;
    end
  end

endmodule

// File: rtl/fp_mul.sv
// rtl/fp_mul.sv - signed fixed-point multiply with round-to-nearest and saturation
// Ports: a, b  signed Q operands
//        y     rounded product, clamped to the Q range
//        sat   product did not fit and was clamped
module fp_mul #(
  parameter int WIDTH    = 32,
  parameter int FRACTION = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  localparam logic signed [2*WIDTH-1:0] HALF  = (2*WIDTH)'(1) << (FRACTION-1);
  localparam logic [WIDTH-1:0]          Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]          Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] rounded;
  logic signed [2*WIDTH-1:0] shifted;
  logic                      fits;

  always_comb begin
    // Low 2W bits of the product are exact for sign-extended operands.
    prod    = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    // Half-LSB bias then arithmetic shift: ties round towards +inf.
    rounded = prod + HALF;
    shifted = rounded >>> FRACTION;
    // Result fits when every bit above the W-bit sign position matches it.
    fits    = (shifted[2*WIDTH-1:WIDTH-1] == '0) || (shifted[2*WIDTH-1:WIDTH-1] == '1);
    sat     = !fits;
    if (fits) begin
      y = shifted[WIDTH-1:0];
    end else if (shifted[2*WIDTH-1]) begin
      y = Q_MIN;
    end else begin
      y = Q_MAX;
    end
  end

endmodule

// File: rtl/fp_dot_acc.sv
// rtl/fp_dot_acc.sv - streaming saturating fixed-point dot-product accumulator
// Ports: clk, rst                       clock, synchronous active-high reset
//        s_valid/s_ready/s_a/s_b/s_last operand beat stream, s_last ends a vector
//        m_valid/m_ready                result handshake
//        m_y, m_sat, m_len_err, m_count saturated sum, sticky saturation,
//                                       forced-termination flag, beat count
module fp_dot_acc
  import fp_pkg::*;
#(
  parameter int WIDTH    = FP_WIDTH,
  parameter int FRACTION = FP_FRACTION,
  parameter int MAX_LEN  = 256,
  parameter int CNT_W    = $clog2(MAX_LEN+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_y,
  output logic             m_sat,
  output logic             m_len_err,
  output logic [CNT_W-1:0] m_count
);

  dot_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p_reg, acc, mul_y, add_y;
  logic             p_valid, p_sat, p_lenerr;
  logic             sat_acc, first, mul_sat, add_sat;
  logic             accept, at_limit, last_beat;

  assign at_limit  = cnt == CNT_W'(MAX_LEN-1);
  assign last_beat = s_last || at_limit;
  assign accept    = s_valid && s_ready;

  fp_mul #(.WIDTH(WIDTH), .FRACTION(FRACTION)) u_mul (
    .a   (s_a),
    .b   (s_b),
    .y   (mul_y),
    .sat (mul_sat)
  );

  fp_add #(.WIDTH(WIDTH)) u_add (
    .a   (acc),
    .b   (p_reg),
    .y   (add_y),
    .sat (add_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // DRAIN waits for the last product to fold into acc before publishing.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      ACC: begin
        s_ready = 1'b1;
        if (s_valid && last_beat) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!p_valid) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (m_valid && m_ready) begin
          state_nxt = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      p_reg     <= '0;
      p_valid   <= 1'b0;
      p_sat     <= 1'b0;
      p_lenerr  <= 1'b0;
      acc       <= '0;
      sat_acc   <= 1'b0;
      first     <= 1'b1;
      m_valid   <= 1'b0;
      m_y       <= '0;
      m_sat     <= 1'b0;
      m_len_err <= 1'b0;
      m_count   <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_reg    <= mul_y;
        p_sat    <= mul_sat;
        p_lenerr <= !s_last && at_limit;
        cnt      <= cnt + CNT_W'(1);
      end
      if (p_valid) begin
        first <= 1'b0;
        if (first) begin
          acc     <= p_reg;
          sat_acc <= p_sat;
        end else begin
          acc     <= add_y;
          sat_acc <= sat_acc | p_sat | add_sat;
        end
      end
      if (state == DRAIN && !p_valid) begin
        m_valid   <= 1'b1;
        m_y       <= acc;
        m_sat     <= sat_acc;
        m_len_err <= p_lenerr;
        m_count   <= cnt;
      end
      if (state == HOLD && m_valid && m_ready) begin
        m_valid <= 1'b0;
        acc     <= '0;
        sat_acc <= 1'b0;
        cnt     <= '0;
        first   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_dot_acc.sv
// tb/tb_fp_dot_acc.sv - directed self-checking bench for fp_dot_acc
module tb_fp_dot_acc;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_y;
  logic        m_sat;
  logic        m_len_err;
  logic [2:0]  m_count;

  int checks = 0;
  int errors = 0;
  int lat;

  fp_dot_acc #(.WIDTH(32), .FRACTION(16), .MAX_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_y       (m_y),
    .m_sat     (m_sat),
    .m_len_err (m_len_err),
    .m_count   (m_count)
  );

  always #5 clk = ~clk;

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
    while (!s_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("FAIL send_ready: s_ready=%0b required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!m_valid && cycles < 20) begin
      @(posedge clk); #1; cycles++;
    end
  endtask

  task automatic take_result();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
    checks++; if (m_y !== 32'h0) begin errors++; $display("FAIL reset_m_y: got %h want 0", m_y); end
    checks++; if ({m_sat, m_len_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {m_sat, m_len_err}); end
    checks++; if (m_count !== 3'd0) begin errors++; $display("FAIL reset_m_count: got %0d want 0", m_count); end
  endtask

  task automatic test_basic_vector();
    send_beat(32'h0001_0000, 32'h0000_8000, 1'b0);
    send_beat(32'h0002_0000, 32'h0000_8000, 1'b0);
    send_beat(32'h0003_0000, 32'h0000_8000, 1'b1);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_drop: got %0b want 0", s_ready); end
    wait_result(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", lat); end
    checks++; if (m_y !== 32'h0003_0000) begin errors++; $display("FAIL basic_m_y: got %h want 00030000", m_y); end
    checks++; if (m_sat !== 1'b0) begin errors++; $display("FAIL basic_m_sat: got %0b want 0", m_sat); end
    checks++; if (m_count !== 3'd3) begin errors++; $display("FAIL basic_m_count: got %0d want 3", m_count); end
    checks++; if (m_len_err !== 1'b0) begin errors++; $display("FAIL basic_len_err: got %0b want 0", m_len_err); end
    take_result();
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL basic_release: m_valid=%0b s_ready=%0b want 0 1", m_valid, s_ready); end
  endtask

  task automatic test_single_beat();
    send_beat(32'hFFFD_0000, 32'hFFFF_8000, 1'b1);
    wait_result(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", lat); end
    checks++; if (m_y !== 32'h0001_8000) begin errors++; $display("FAIL single_m_y: got %h want 00018000", m_y); end
    checks++; if (m_count !== 3'd1) begin errors++; $display("FAIL single_m_count: got %0d want 1", m_count); end
    take_result();
  endtask

  task automatic test_saturation();
    send_beat(32'h7FFF_0000, 32'h03E8_0000, 1'b0);
    send_beat(32'hFFFF_0000, FP_ONE, 1'b1);
    wait_result(lat);
    checks++; if (m_y !== 32'h7FFE_FFFF) begin errors++; $display("FAIL sat_m_y: got %h want 7ffeffff", m_y); end
    checks++; if (m_sat !== 1'b1) begin errors++; $display("FAIL sat_m_sat: got %0b want 1", m_sat); end
    checks++; if (m_count !== 3'd2) begin errors++; $display("FAIL sat_m_count: got %0d want 2", m_count); end
    take_result();
  endtask

  task automatic test_back_pressure();
    send_beat(FP_ONE, 32'h0002_0000, 1'b1);
    wait_result(lat);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b want 1", m_valid); end
    s_valid = 1'b1; s_a = 32'h0100_0000; s_b = 32'h0100_0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_y !== 32'h0002_0000 || m_count !== 3'd1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: s_ready=%0b m_valid=%0b m_y=%h m_count=%0d want 0 1 00020000 1",
                 i, s_ready, m_valid, m_y, m_count);
      end
    end
    s_valid = 1'b0;
    take_result();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %0b want 1", s_ready); end
    send_beat(32'h0000_8000, FP_ONE, 1'b1);
    wait_result(lat);
    checks++; if (m_y !== 32'h0000_8000) begin errors++; $display("FAIL bp_fresh_m_y: got %h want 00008000", m_y); end
    checks++; if (m_count !== 3'd1) begin errors++; $display("FAIL bp_fresh_count: got %0d want 1", m_count); end
    take_result();
  endtask

  task automatic test_len_limit();
    for (int i = 0; i < 4; i++) send_beat(FP_ONE, FP_ONE, 1'b0);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL len_ready_drop: got %0b want 0", s_ready); end
    wait_result(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL len_latency: got %0d want 2", lat); end
    checks++; if (m_y !== 32'h0004_0000) begin errors++; $display("FAIL len_m_y: got %h want 00040000", m_y); end
    checks++; if (m_len_err !== 1'b1) begin errors++; $display("FAIL len_err: got %0b want 1", m_len_err); end
    checks++; if (m_count !== 3'd4) begin errors++; $display("FAIL len_count: got %0d want 4", m_count); end
    take_result();
    send_beat(FP_ONE, FP_ONE, 1'b1);
    wait_result(lat);
    checks++; if (m_count !== 3'd1 || m_len_err !== 1'b0) begin errors++; $display("FAIL len_next_vec: count=%0d len_err=%0b want 1 0", m_count, m_len_err); end
    checks++; if (m_y !== 32'h0001_0000) begin errors++; $display("FAIL len_next_m_y: got %h want 00010000", m_y); end
    take_result();
  endtask

  task automatic test_reset_mid_vector();
    send_beat(32'h0005_0000, FP_ONE, 1'b0);
    send_beat(32'h0005_0000, FP_ONE, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state: m_valid=%0b s_ready=%0b want 0 1", m_valid, s_ready); end
    send_beat(FP_ONE, FP_ONE, 1'b1);
    wait_result(lat);
    checks++; if (m_y !== 32'h0001_0000) begin errors++; $display("FAIL rstmid_m_y: got %h want 00010000", m_y); end
    checks++; if (m_count !== 3'd1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", m_count); end
    checks++; if (m_sat !== 1'b0) begin errors++; $display("FAIL rstmid_sat: got %0b want 0", m_sat); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic_vector();
    test_single_beat();
    test_saturation();
    test_back_pressure();
    test_len_limit();
    test_reset_mid_vector();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
